// File: rtl/act_mux_pkg.sv
// Shared definitions for the multi-bank activation demux: FSM encoding,
// config word order, status bit layout and the lane extraction helper.
package act_mux_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CFG  = 2'd1,
    ST_RUN  = 2'd2
  } state_e;

  localparam logic [1:0] CFG_WORD_DIMS = 2'd0;
  localparam logic [1:0] CFG_WORD_LEN  = 2'd1;
  localparam logic [1:0] CFG_WORD_NB   = 2'd2;

  localparam int unsigned STS_STATE_LSB = 0;
  localparam int unsigned STS_PF_BIT    = 2;
  localparam int unsigned STS_RD0_BIT   = 3;

  localparam int unsigned BEAT_MAX_W = 512;
  localparam int unsigned LANE_MAX_W = 64;

  // Caller truncates the result to its lane width.
  function automatic logic [LANE_MAX_W-1:0] lane_extract(
    input logic [BEAT_MAX_W-1:0] beat,
    input int unsigned           k,
    input int unsigned           stride
  );
    return LANE_MAX_W'(beat >> (k * stride));
  endfunction

endpackage

// File: rtl/act_mux_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO holding one activation bank.
// The head word is presented combinationally; count and prog_full track occupancy.
module act_mux_fifo_fwft #(
  parameter int unsigned W         = 48,
  parameter int unsigned DEPTH     = 512,
  parameter int unsigned PROG_FULL = 504,
  parameter int unsigned CNT_W     = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [W-1:0]     din_i,
  input  logic             rd_en_i,
  output logic [W-1:0]     dout_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o,
  output logic             prog_full_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr_en_i) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en_i) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en_i, rd_en_i})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o      = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign prog_full_o = (count_q >= CNT_W'(PROG_FULL));

endmodule

// File: rtl/act_mux_nbank.sv
// Activation demux: lanes of each input beat go round-robin into nb FWFT banks,
// and one bank is drained per image line so each output line is one channel group.
module act_mux_nbank
  import act_mux_pkg::*;
#(
  parameter int unsigned DATA_W      = 12,
  parameter int unsigned LANE_STRIDE = 16,
  parameter int unsigned LANES       = 4,
  parameter int unsigned IN_W        = 64,
  parameter int unsigned BANKS       = 2,
  parameter int unsigned FIFO_DEPTH  = 512,
  parameter int unsigned PROG_FULL   = 504,
  parameter int unsigned CNT_W       = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    s_config_valid,
  output logic                    s_config_ready,
  input  logic [31:0]             s_config_data,
  input  logic                    s_data_valid,
  output logic                    s_data_ready,
  input  logic [IN_W-1:0]         s_data,
  output logic [LANES*DATA_W-1:0] act_data,
  output logic                    act_valid,
  input  logic                    act_ready,
  output logic                    act_last,
  output logic [CNT_W-1:0]        act_dcnt,
  output logic [3:0]              status
);
  localparam int unsigned LW     = LANES * DATA_W;
  localparam int unsigned BANK_W = $clog2(BANKS);

  state_e            state_q, state_d;
  logic              alive_q;
  logic [1:0]        cfg_idx_q, cfg_idx_d;
  logic [15:0]       img_w_q, img_w_d;
  logic [15:0]       img_h_q, img_h_d;
  logic [31:0]       total_len_q, total_len_d;
  logic [3:0]        nb_q, nb_d;
  logic [31:0]       in_cnt_q, in_cnt_d;
  logic [31:0]       out_cnt_q, out_cnt_d;
  logic [15:0]       line_cnt_q, line_cnt_d;
  logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
  logic [BANK_W-1:0] rd_bank_q, rd_bank_d;

  logic              wr_vld_p0_q;
  logic [BANK_W-1:0] wr_bank_p0_q;
  logic [LW-1:0]     wr_data_p0_q;

  logic [LW-1:0]     beat_lanes;
  logic [LW-1:0]     fifo_dout [BANKS];
  logic [CNT_W-1:0]  fifo_cnt  [BANKS];
  logic [BANKS-1:0]  fifo_empty, fifo_pf, fifo_wr, fifo_rd;
  logic              any_pf, run, cfg_acc, beat_acc, pop;
  logic [3:0]        nb_sel;
  logic              unused_img_h;

  function automatic logic [BANK_W-1:0] bank_next(input logic [BANK_W-1:0] cur,
                                                  input logic [3:0]        nb);
    return ((4'(cur) + 4'd1) >= nb) ? '0 : cur + BANK_W'(1);
  endfunction

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    assign beat_lanes[k*DATA_W +: DATA_W] =
      DATA_W'(lane_extract(BEAT_MAX_W'(s_data), k, LANE_STRIDE));
  end

  for (genvar b = 0; b < BANKS; b++) begin : g_bank
    assign fifo_wr[b] = wr_vld_p0_q && (wr_bank_p0_q == BANK_W'(b));
    assign fifo_rd[b] = pop && (rd_bank_q == BANK_W'(b));
    act_mux_fifo_fwft #(
      .W(LW), .DEPTH(FIFO_DEPTH), .PROG_FULL(PROG_FULL), .CNT_W(CNT_W)
    ) u_fifo (
      .clk(clk), .rst_n(rst_n),
      .wr_en_i(fifo_wr[b]), .din_i(wr_data_p0_q),
      .rd_en_i(fifo_rd[b]), .dout_o(fifo_dout[b]),
      .empty_o(fifo_empty[b]), .count_o(fifo_cnt[b]),
      .prog_full_o(fifo_pf[b])
    );
  end

  // Only banks in the active subset may throttle the input.
  always_comb begin
    any_pf = 1'b0;
    for (int unsigned b = 0; b < BANKS; b++) begin
      if ((4'(b) < nb_q) && fifo_pf[b]) any_pf = 1'b1;
    end
  end

  assign run            = (state_q == ST_RUN);
  assign s_config_ready = alive_q && !run;
  assign s_data_ready   = run && (in_cnt_q < total_len_q) && !any_pf;
  assign act_valid      = run && !fifo_empty[rd_bank_q];
  assign act_data       = act_valid ? fifo_dout[rd_bank_q] : '0;
  assign act_last       = act_valid && (out_cnt_q == total_len_q - 32'd1);
  assign act_dcnt       = fifo_cnt[rd_bank_q];
  assign cfg_acc        = s_config_valid && s_config_ready;
  assign beat_acc       = s_data_valid && s_data_ready;
  assign pop            = act_valid && act_ready;
  assign nb_sel         = s_config_data[3:0];
  assign unused_img_h   = ^img_h_q;

  always_comb begin
    status                                   = '0;
    status[STS_STATE_LSB +: 2]               = state_q;
    status[STS_PF_BIT]                       = any_pf;
    status[STS_RD0_BIT]                      = (rd_bank_q == '0);
  end

  always_comb begin
    state_d     = state_q;
    cfg_idx_d   = cfg_idx_q;
    img_w_d     = img_w_q;
    img_h_d     = img_h_q;
    total_len_d = total_len_q;
    nb_d        = nb_q;
    in_cnt_d    = in_cnt_q;
    out_cnt_d   = out_cnt_q;
    line_cnt_d  = line_cnt_q;
    wr_bank_d   = wr_bank_q;
    rd_bank_d   = rd_bank_q;
    case (state_q)
      ST_IDLE: begin
        if (cfg_acc) begin
          img_w_d   = (s_config_data[15:0] == '0) ? 16'd1 : s_config_data[15:0];
          img_h_d   = s_config_data[31:16];
          cfg_idx_d = CFG_WORD_LEN;
          state_d   = ST_CFG;
        end
      end
      ST_CFG: begin
        if (cfg_acc) begin
          if (cfg_idx_q == CFG_WORD_LEN) begin
            total_len_d = s_config_data;
            cfg_idx_d   = CFG_WORD_NB;
          end else begin
            nb_d    = ((nb_sel == '0) || (nb_sel > 4'(BANKS))) ? 4'(BANKS) : nb_sel;
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (beat_acc) begin
          in_cnt_d  = in_cnt_q + 32'd1;
          wr_bank_d = bank_next(wr_bank_q, nb_q);
        end
        if (pop) begin
          out_cnt_d = out_cnt_q + 32'd1;
          if (line_cnt_q == img_w_q - 16'd1) begin
            line_cnt_d = '0;
            rd_bank_d  = bank_next(rd_bank_q, nb_q);
          end else begin
            line_cnt_d = line_cnt_q + 16'd1;
          end
        end
        // Job end: every accepted beat has been popped, so the banks are empty.
        if ((total_len_q == '0) || (pop && act_last)) begin
          state_d    = ST_IDLE;
          cfg_idx_d  = CFG_WORD_DIMS;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          line_cnt_d = '0;
          wr_bank_d  = '0;
          rd_bank_d  = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      alive_q      <= 1'b0;
      cfg_idx_q    <= CFG_WORD_DIMS;
      img_w_q      <= 16'd1;
      img_h_q      <= '0;
      total_len_q  <= '0;
      nb_q         <= '0;
      in_cnt_q     <= '0;
      out_cnt_q    <= '0;
      line_cnt_q   <= '0;
      wr_bank_q    <= '0;
      rd_bank_q    <= '0;
      wr_vld_p0_q  <= 1'b0;
      wr_bank_p0_q <= '0;
    end else begin
      state_q      <= state_d;
      alive_q      <= 1'b1;
      cfg_idx_q    <= cfg_idx_d;
      img_w_q      <= img_w_d;
      img_h_q      <= img_h_d;
      total_len_q  <= total_len_d;
      nb_q         <= nb_d;
      in_cnt_q     <= in_cnt_d;
      out_cnt_q    <= out_cnt_d;
      line_cnt_q   <= line_cnt_d;
      wr_bank_q    <= wr_bank_d;
      rd_bank_q    <= rd_bank_d;
      wr_vld_p0_q  <= beat_acc;
      if (beat_acc) wr_bank_p0_q <= wr_bank_q;
    end
  end

  // p0: accepted beat held one cycle, then written into its bank.
  always_ff @(posedge clk) begin
    if (beat_acc) wr_data_p0_q <= beat_lanes;
  end

endmodule
